oled_text_feeder: RTL

// - Upstream stage of the PmodOLED text driver: turns a byte stream of ASCII characters into a 4x16 text screen.
// - Handles cursor, control codes and scrolling, and publishes the screen as DATA_STRING[511:0].
// - Drives the driver's EN/FIN handshake so the panel is redrawn whenever the screen changes.

---
 rtl/oled_text_feeder_if.sv | 9 +
 rtl/oled_text_feeder.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/oled_text_feeder_if.sv
// Character stream handshake between a byte source and oled_text_feeder.
interface oled_text_feeder_if;
  logic       CHAR_VALID;
  logic [7:0] CHAR_DATA;
  logic       CHAR_READY;

  modport master (output CHAR_VALID, output CHAR_DATA, input CHAR_READY);
  modport slave  (input CHAR_VALID, input CHAR_DATA, output CHAR_READY);
endinterface

// File: rtl/oled_text_feeder.sv
// ASCII stream to 4x16 text screen with cursor, control codes and scrolling; publishes
// snapshots to the PmodOLED driver through an EN/FIN refresh handshake.
module oled_text_feeder #(
  parameter logic [7:0]  BLANK_CHAR   = 8'h20,
  parameter int unsigned IDLE_REFRESH = 1000
) (
  input  logic                     CLK,
  input  logic                     RST,
  oled_text_feeder_if.slave        chr,
  input  logic                     FORCE_REFRESH,
  output logic [511:0]             DATA_STRING,
  output logic                     OLED_EN,
  input  logic                     OLED_FIN,
  output logic                     BUSY
);

  localparam int unsigned IdleW = $clog2(IDLE_REFRESH + 1);
  localparam logic [IdleW-1:0] IdleMax = IdleW'(IDLE_REFRESH);

  typedef enum logic {InAccept, InScroll} in_state_e;
  typedef enum logic [2:0] {RfIdle, RfSnap, RfEnHi, RfWaitFin, RfWaitLow} rf_state_e;

  in_state_e        in_state_q, in_state_d;
  rf_state_e        rf_state_q, rf_state_d;
  logic [511:0]     scr_q, scr_d;
  logic [511:0]     data_q, data_d;
  logic [1:0]       row_q, row_d;
  logic [3:0]       col_q, col_d;
  logic [IdleW-1:0] idle_q, idle_d;
  logic             dirty_q, dirty_d;
  logic             pend_q, pend_d;
  logic             en_q, en_d;

  logic             accept;
  logic             changed;
  logic [3:0]       col_m1;
  logic [8:0]       cur_lsb, bs_lsb;

  assign chr.CHAR_READY = RST && (in_state_q == InAccept);
  assign accept         = chr.CHAR_VALID && chr.CHAR_READY;
  assign col_m1         = col_q - 4'd1;
  // Bit offset of char (r,c) is 8*(63-(16r+c)), i.e. the inverted position times 8.
  assign cur_lsb        = {~row_q, ~col_q, 3'b000};
  assign bs_lsb         = {~row_q, ~col_m1, 3'b000};

  always_comb begin
    scr_d      = scr_q;
    row_d      = row_q;
    col_d      = col_q;
    in_state_d = in_state_q;
    changed    = 1'b0;
    if (in_state_q == InScroll) begin
      scr_d      = {scr_q[383:0], {16{BLANK_CHAR}}};
      row_d      = 2'd3;
      col_d      = 4'd0;
      in_state_d = InAccept;
      changed    = 1'b1;
    end else if (accept) begin
      if (chr.CHAR_DATA >= 8'h20 && chr.CHAR_DATA <= 8'h7E) begin
        scr_d[cur_lsb +: 8] = chr.CHAR_DATA;
        changed             = 1'b1;
        if (col_q == 4'd15) begin
          col_d = 4'd0;
          if (row_q == 2'd3) in_state_d = InScroll;
          else               row_d      = row_q + 2'd1;
        end else begin
          col_d = col_q + 4'd1;
        end
      end else begin
        case (chr.CHAR_DATA)
          8'h0A: begin
            col_d   = 4'd0;
            changed = 1'b1;
            if (row_q == 2'd3) in_state_d = InScroll;
            else               row_d      = row_q + 2'd1;
          end
          8'h0D: begin
            col_d   = 4'd0;
            changed = 1'b1;
          end
          8'h08: begin
            if (col_q != 4'd0) begin
              col_d              = col_m1;
              scr_d[bs_lsb +: 8] = BLANK_CHAR;
              changed            = 1'b1;
            end
          end
          8'h0C: begin
            scr_d   = {64{BLANK_CHAR}};
            row_d   = 2'd0;
            col_d   = 4'd0;
            changed = 1'b1;
          end
          default: ;
        endcase
      end
    end
  end

  always_comb begin
    rf_state_d = rf_state_q;
    data_d     = data_q;
    en_d       = en_q;
    pend_d     = pend_q;
    dirty_d    = dirty_q;
    unique case (rf_state_q)
      RfIdle: begin
        if (!OLED_FIN && ((dirty_q && idle_q == IdleMax) || pend_q)) rf_state_d = RfSnap;
      end
      RfSnap: begin
        data_d     = scr_q;
        dirty_d    = 1'b0;
        pend_d     = 1'b0;
        en_d       = 1'b1;
        rf_state_d = RfEnHi;
      end
      RfEnHi: rf_state_d = RfWaitFin;
      RfWaitFin: begin
        if (OLED_FIN) begin
          en_d       = 1'b0;
          rf_state_d = RfWaitLow;
        end
      end
      RfWaitLow: begin
        if (!OLED_FIN) rf_state_d = RfIdle;
      end
      default: rf_state_d = RfIdle;
    endcase
    // A write on the snapshot edge keeps the screen dirty for the next refresh.
    if (FORCE_REFRESH) pend_d  = 1'b1;
    if (changed)       dirty_d = 1'b1;
    if (accept)                idle_d = '0;
    else if (idle_q == IdleMax) idle_d = idle_q;
    else                        idle_d = idle_q + IdleW'(1);
  end

  always_ff @(posedge CLK) begin
    if (!RST) begin
      in_state_q <= InAccept;
      rf_state_q <= RfIdle;
      scr_q      <= {64{BLANK_CHAR}};
      data_q     <= {64{BLANK_CHAR}};
      row_q      <= 2'd0;
      col_q      <= 4'd0;
      idle_q     <= '0;
      dirty_q    <= 1'b1;
      pend_q     <= 1'b0;
      en_q       <= 1'b0;
    end else begin
      in_state_q <= in_state_d;
      rf_state_q <= rf_state_d;
      scr_q      <= scr_d;
      data_q     <= data_d;
      row_q      <= row_d;
      col_q      <= col_d;
      idle_q     <= idle_d;
      dirty_q    <= dirty_d;
      pend_q     <= pend_d;
      en_q       <= en_d;
    end
  end

  assign DATA_STRING = data_q;
  assign OLED_EN     = en_q;
  assign BUSY        = (rf_state_q != RfIdle);

endmodule
